// File: rtl/i2c_master_wr.sv
// i2c_master_wr: write-only I2C master sending START, NBYTES bytes, STOP, gap.
// A quarter-period divider paces one registered FSM; SDA is open-drain.
module i2c_master_wr #(
    parameter int NBYTES    = 3,
    parameter int CLK_DIV   = 125,
    parameter bit ACK_CHECK = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [8*NBYTES-1:0] din,
    input  logic                wr_i2c,
    output logic                i2c_idle,
    output logic                done,
    output logic                nack_err,
    output logic                i2c_sclk,
    inout  wire                 i2c_sdat
);

    localparam int DW    = 8 * NBYTES;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BC_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        ACK,
        STOP,
        TURN
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div;
    logic [1:0]        q;
    logic [2:0]        bit_cnt;
    logic [BC_W-1:0]   byte_cnt;
    logic [DW-1:0]     shreg;
    logic              sda_low;
    logic              sda_s1;
    logic              sda_s2;
    logic              ack_bit;
    logic              tick;

    assign tick     = (div == DIV_W'(CLK_DIV - 1));
    assign i2c_sdat = sda_low ? 1'b0 : 1'bz;

    // Outputs are loaded at each quarter boundary with the values of the
    // quarter being entered, so SCL/SDA only ever move on a tick.
    always_ff @(posedge clk) begin
        sda_s1 <= i2c_sdat;
        sda_s2 <= sda_s1;
        done   <= 1'b0;
        if (reset) begin
            state    <= IDLE;
            div      <= '0;
            q        <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            sda_low  <= 1'b0;
            ack_bit  <= 1'b0;
            i2c_sclk <= 1'b1;
            i2c_idle <= 1'b1;
            nack_err <= 1'b0;
        end else if (state == IDLE) begin
            if (wr_i2c) begin
                state    <= START;
                div      <= '0;
                q        <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                shreg    <= din;
                nack_err <= 1'b0;
                i2c_idle <= 1'b0;
                i2c_sclk <= 1'b1;
                sda_low  <= 1'b0;
            end
        end else if (!tick) begin
            div <= div + DIV_W'(1);
        end else begin
            div <= '0;
            q   <= q + 2'd1;
            unique case (state)
                START: begin
                    if (q == 2'd1) sda_low <= 1'b1;
                    if (q == 2'd3) begin
                        state    <= DATA;
                        i2c_sclk <= 1'b0;
                        sda_low  <= ~shreg[DW-1];
                    end
                end
                DATA: begin
                    if (q == 2'd1) i2c_sclk <= 1'b1;
                    if (q == 2'd3) begin
                        i2c_sclk <= 1'b0;
                        shreg    <= shreg << 1;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state   <= ACK;
                            sda_low <= 1'b0;
                        end else begin
                            sda_low <= ~shreg[DW-2];
                        end
                    end
                end
                ACK: begin
                    if (q == 2'd1) i2c_sclk <= 1'b1;
                    if (q == 2'd2) ack_bit <= sda_s2;
                    if (q == 2'd3) begin
                        i2c_sclk <= 1'b0;
                        if (ACK_CHECK && ack_bit) begin
                            nack_err <= 1'b1;
                            state    <= STOP;
                            sda_low  <= 1'b1;
                        end else if (byte_cnt == BC_W'(NBYTES - 1)) begin
                            state   <= STOP;
                            sda_low <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + BC_W'(1);
                            state    <= DATA;
                            sda_low  <= ~shreg[DW-1];
                        end
                    end
                end
                STOP: begin
                    if (q == 2'd1) i2c_sclk <= 1'b1;
                    if (q == 2'd2) sda_low <= 1'b0;
                    if (q == 2'd3) state <= TURN;
                end
                TURN: begin
                    if (q == 2'd3) begin
                        state    <= IDLE;
                        done     <= 1'b1;
                        i2c_idle <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_wr.sv
// tb_i2c_master_wr: three i2c_master_wr configurations checked against a
// byte/ACK-level bus model, an ACKing slave and the transaction length rule.
module tb_i2c_master_wr;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0]  wr;
    logic [23:0] din0;
    logic [23:0] din1;
    logic [15:0] din2;
    wire  [2:0]  idle_v;
    wire  [2:0]  done_v;
    wire  [2:0]  nack_v;
    wire  [2:0]  scl_v;
    wire         sda0;
    wire         sda1;
    wire         sda2;
    logic [2:0]  slv_low = 3'b000;

    pullup (sda0);
    pullup (sda1);
    pullup (sda2);
    assign sda0 = slv_low[0] ? 1'b0 : 1'bz;
    assign sda1 = slv_low[1] ? 1'b0 : 1'bz;
    assign sda2 = slv_low[2] ? 1'b0 : 1'bz;
    wire [2:0] sda_v = {sda2, sda1, sda0};

    i2c_master_wr #(.NBYTES(3), .CLK_DIV(4), .ACK_CHECK(1'b1)) u_ack (
        .clk(clk), .reset(reset), .din(din0), .wr_i2c(wr[0]),
        .i2c_idle(idle_v[0]), .done(done_v[0]), .nack_err(nack_v[0]),
        .i2c_sclk(scl_v[0]), .i2c_sdat(sda0)
    );
    i2c_master_wr #(.NBYTES(3), .CLK_DIV(4), .ACK_CHECK(1'b0)) u_noack (
        .clk(clk), .reset(reset), .din(din1), .wr_i2c(wr[1]),
        .i2c_idle(idle_v[1]), .done(done_v[1]), .nack_err(nack_v[1]),
        .i2c_sclk(scl_v[1]), .i2c_sdat(sda1)
    );
    i2c_master_wr #(.NBYTES(2), .CLK_DIV(5), .ACK_CHECK(1'b1)) u_two (
        .clk(clk), .reset(reset), .din(din2), .wr_i2c(wr[2]),
        .i2c_idle(idle_v[2]), .done(done_v[2]), .nack_err(nack_v[2]),
        .i2c_sclk(scl_v[2]), .i2c_sdat(sda2)
    );

    int vectors = 0;
    int miscompares = 0;

    // Bus monitor and slave: bits logged on SCL rise, START/STOP on SDA
    // edges while SCL stays high; slave ACKs bytes whose mask bit is set.
    logic [2:0]   p_scl = 3'b111;
    logic [2:0]   p_sda = 3'b111;
    logic [127:0] obs [3];
    int           obs_n [3];
    int           starts [3];
    int           stops [3];
    int           rises [3];
    logic [7:0]   mask [3];

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            logic s;
            s = sda_v[g];
            if (!p_scl[g] && scl_v[g]) begin
                obs[g]   = {obs[g][126:0], s};
                obs_n[g] = obs_n[g] + 1;
                rises[g] = rises[g] + 1;
            end
            if (p_scl[g] && !scl_v[g])
                slv_low[g] = (rises[g] % 9 == 8) && mask[g][rises[g] / 9];
            if (p_scl[g] && scl_v[g] && p_sda[g] && !s) begin
                starts[g] = starts[g] + 1;
                rises[g]  = 0;
            end
            if (p_scl[g] && scl_v[g] && !p_sda[g] && s)
                stops[g] = stops[g] + 1;
            p_scl[g] = scl_v[g];
            p_sda[g] = s;
        end
    end

    task automatic clear_mon(input int g);
        obs[g]     = '0;
        obs_n[g]   = 0;
        starts[g]  = 0;
        stops[g]   = 0;
        rises[g]   = 0;
        slv_low[g] = 1'b0;
    endtask

    // Reference: bus bits seen on SCL rises (data, ACK slot, STOP clock)
    // and transaction length in quarters.
    function automatic void model(
        input  logic [63:0]  d,
        input  int           nb,
        input  logic [7:0]   m,
        input  bit           ackchk,
        output logic [127:0] eb,
        output int           en,
        output int           eq,
        output logic         enack
    );
        eb    = '0;
        en    = 0;
        eq    = 12;
        enack = 1'b0;
        for (int k = 0; k < nb; k++) begin
            for (int i = 0; i < 8; i++) begin
                eb = {eb[126:0], d[8*nb-1-8*k-i]};
                en++;
            end
            eb = {eb[126:0], ~m[k]};
            en++;
            eq += 36;
            if (ackchk && !m[k]) begin
                enack = 1'b1;
                break;
            end
        end
        eb = {eb[126:0], 1'b0};
        en++;
    endfunction

    task automatic run(
        input  int          g,
        input  logic [63:0] d,
        input  int          glitch,
        output int          lat,
        output logic        idle_acc,
        output logic        done_nxt
    );
        clear_mon(g);
        if (g == 0) din0 = d[23:0];
        else if (g == 1) din1 = d[23:0];
        else din2 = d[15:0];
        @(negedge clk);
        wr[g] = 1'b1;
        @(posedge clk);
        #1;
        wr[g] = 1'b0;
        idle_acc = idle_v[g];
        lat = -1;
        for (int n = 1; n <= 4000; n++) begin
            @(posedge clk);
            #1;
            wr[g] = (n == glitch);
            if (n == glitch && g == 0) din0 = 24'($urandom);
            if (done_v[g]) begin
                lat = n;
                break;
            end
        end
        @(posedge clk);
        #1;
        done_nxt = done_v[g];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({scl_v, sda_v, idle_v, done_v, nack_v} !== 15'b111_111_111_000_000) begin
            miscompares++;
            $display("FAIL reset_state: got %b want %b",
                     {scl_v, sda_v, idle_v, done_v, nack_v}, 15'b111_111_111_000_000);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [127:0] eb;
        int en, eq, lat;
        logic enk, ia, dn;
        mask[0] = 8'hFF;
        model(64'h341E00, 3, 8'hFF, 1'b1, eb, en, eq, enk);
        run(0, 64'h341E00, 0, lat, ia, dn);
        vectors++;
        if (lat !== 480 || lat !== eq * 4) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d want %0d", lat, eq * 4);
        end
        vectors++;
        if (obs_n[0] !== en || obs[0] !== eb) begin
            miscompares++;
            $display("FAIL basic_bits: got %0d/%h want %0d/%h", obs_n[0], obs[0], en, eb);
        end
        vectors++;
        if (starts[0] !== 1 || stops[0] !== 1) begin
            miscompares++;
            $display("FAIL basic_framing: got %0d/%0d want 1/1", starts[0], stops[0]);
        end
        vectors++;
        if ({ia, dn, idle_v[0], nack_v[0]} !== 4'b0010) begin
            miscompares++;
            $display("FAIL basic_flags: got %b want 0010", {ia, dn, idle_v[0], nack_v[0]});
        end
    endtask

    task automatic test_random();
        logic [127:0] eb;
        logic [63:0] d;
        int en, eq, lat;
        logic enk, ia, dn;
        for (int t = 0; t < 5; t++) begin
            d = {40'h0, 24'($urandom)};
            mask[0] = 8'($urandom) | 8'($urandom);
            model(d, 3, mask[0], 1'b1, eb, en, eq, enk);
            run(0, d, 0, lat, ia, dn);
            vectors++;
            if (lat !== eq * 4) begin
                miscompares++;
                $display("FAIL rand_latency[%0d]: got %0d want %0d", t, lat, eq * 4);
            end
            vectors++;
            if (obs_n[0] !== en || obs[0] !== eb) begin
                miscompares++;
                $display("FAIL rand_bits[%0d]: got %0d/%h want %0d/%h", t, obs_n[0], obs[0], en, eb);
            end
            vectors++;
            if (nack_v[0] !== enk || starts[0] !== 1 || stops[0] !== 1) begin
                miscompares++;
                $display("FAIL rand_nack_framing[%0d]: got %b/%0d/%0d want %b/1/1",
                         t, nack_v[0], starts[0], stops[0], enk);
            end
        end
    endtask

    task automatic test_nack();
        logic [127:0] eb;
        logic [63:0] d;
        int en, eq, lat;
        logic enk, ia, dn;
        d = {40'h0, 24'($urandom)};
        mask[0] = 8'hFE;
        model(d, 3, 8'hFE, 1'b1, eb, en, eq, enk);
        run(0, d, 0, lat, ia, dn);
        vectors++;
        if (lat !== 192 || lat !== eq * 4) begin
            miscompares++;
            $display("FAIL nack_latency: got %0d want %0d", lat, eq * 4);
        end
        vectors++;
        if (obs_n[0] !== en || obs[0] !== eb || stops[0] !== 1) begin
            miscompares++;
            $display("FAIL nack_bits: got %0d/%h/%0d want %0d/%h/1",
                     obs_n[0], obs[0], stops[0], en, eb);
        end
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (nack_v[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL nack_sticky: got %b want 1", nack_v[0]);
        end
        mask[0] = 8'hFF;
        run(0, {40'h0, 24'($urandom)}, 0, lat, ia, dn);
        vectors++;
        if (nack_v[0] !== 1'b0 || lat !== 480) begin
            miscompares++;
            $display("FAIL nack_cleared: got %b/%0d want 0/480", nack_v[0], lat);
        end
    endtask

    task automatic test_no_ack_check();
        logic [127:0] eb;
        logic [63:0] d;
        int en, eq, lat;
        logic enk, ia, dn;
        d = {40'h0, 24'($urandom)};
        mask[1] = 8'h00;
        model(d, 3, 8'h00, 1'b0, eb, en, eq, enk);
        run(1, d, 0, lat, ia, dn);
        vectors++;
        if (lat !== 480 || lat !== eq * 4) begin
            miscompares++;
            $display("FAIL noack_latency: got %0d want %0d", lat, eq * 4);
        end
        vectors++;
        if (obs_n[1] !== en || obs[1] !== eb || nack_v[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL noack_bits: got %0d/%h/%b want %0d/%h/0",
                     obs_n[1], obs[1], nack_v[1], en, eb);
        end
    endtask

    task automatic test_busy_ignore();
        logic [127:0] eb;
        logic [63:0] d;
        int en, eq, lat;
        logic enk, ia, dn;
        d = {40'h0, 24'($urandom)};
        mask[0] = 8'hFF;
        model(d, 3, 8'hFF, 1'b1, eb, en, eq, enk);
        run(0, d, 99, lat, ia, dn);
        vectors++;
        if (starts[0] !== 1 || stops[0] !== 1) begin
            miscompares++;
            $display("FAIL busy_framing: got %0d/%0d want 1/1", starts[0], stops[0]);
        end
        vectors++;
        if (obs_n[0] !== en || obs[0] !== eb || lat !== eq * 4) begin
            miscompares++;
            $display("FAIL busy_bits: got %0d/%h/%0d want %0d/%h/%0d",
                     obs_n[0], obs[0], lat, en, eb, eq * 4);
        end
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (idle_v[0] !== 1'b1 || starts[0] !== 1) begin
            miscompares++;
            $display("FAIL busy_no_requeue: got %b/%0d want 1/1", idle_v[0], starts[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] eb;
        logic [63:0] d;
        int en, eq, lat, k;
        logic enk, ia, dn;
        mask[0] = 8'hFF;
        clear_mon(0);
        din0 = 24'($urandom);
        @(negedge clk);
        wr[0] = 1'b1;
        @(posedge clk);
        #1;
        wr[0] = 1'b0;
        k = $urandom_range(170, 270);
        repeat (k) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({scl_v[0], sda_v[0], idle_v[0], done_v[0], nack_v[0]} !== 5'b11100) begin
            miscompares++;
            $display("FAIL midreset_state: got %b want 11100",
                     {scl_v[0], sda_v[0], idle_v[0], done_v[0], nack_v[0]});
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        d = {40'h0, 24'($urandom)};
        model(d, 3, 8'hFF, 1'b1, eb, en, eq, enk);
        run(0, d, 0, lat, ia, dn);
        vectors++;
        if (obs_n[0] !== en || obs[0] !== eb || lat !== eq * 4) begin
            miscompares++;
            $display("FAIL midreset_restart: got %0d/%h/%0d want %0d/%h/%0d",
                     obs_n[0], obs[0], lat, en, eb, eq * 4);
        end
    endtask

    task automatic test_two_byte();
        logic [127:0] eb;
        logic [63:0] d;
        int en, eq, lat;
        logic enk, ia, dn;
        for (int t = 0; t < 2; t++) begin
            d = {48'h0, 16'($urandom)};
            mask[2] = 8'hFF;
            model(d, 2, 8'hFF, 1'b1, eb, en, eq, enk);
            run(2, d, 0, lat, ia, dn);
            vectors++;
            if (lat !== 420 || lat !== eq * 5) begin
                miscompares++;
                $display("FAIL two_latency[%0d]: got %0d want %0d", t, lat, eq * 5);
            end
            vectors++;
            if (obs_n[2] !== 19 || obs[2] !== eb || starts[2] !== 1 || stops[2] !== 1) begin
                miscompares++;
                $display("FAIL two_bits[%0d]: got %0d/%h/%0d/%0d want %0d/%h/1/1",
                         t, obs_n[2], obs[2], starts[2], stops[2], en, eb);
            end
        end
    endtask

    initial begin
        wr   = 3'b000;
        din0 = '0;
        din1 = '0;
        din2 = '0;
        for (int g = 0; g < 3; g++) begin
            mask[g] = 8'hFF;
            clear_mon(g);
        end
        test_reset();
        test_basic();
        test_random();
        test_nack();
        test_no_ack_check();
        test_busy_ignore();
        test_reset_mid();
        test_two_byte();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
